// File: rtl/split_check_sched.sv
// split_check_sched: round-robin scheduler that shares one split-constraint
// checker among solver requesters, with saturating pass/fail statistics.
module split_check_sched #(
  parameter int NUM_REQ = 4,
  parameter int VEC_W   = 64,
  parameter int TAG_W   = 4,
  parameter int CHK_LAT = 0,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*VEC_W-1:0] req_vec,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     chk_valid,
  output logic [VEC_W-1:0]         chk_vec,
  input  logic                     chk_x,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_pass,
  output logic [15:0]              pass_cnt,
  output logic [15:0]              fail_cnt,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT_LD = 4'((CHK_LAT > 0) ? CHK_LAT - 1 : 0);

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [3:0]      lat_cnt;
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] cand;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) begin
      req_ready[win] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      lat_cnt    <= '0;
      chk_valid  <= 1'b0;
      chk_vec    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rsp_pass   <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            chk_vec    <= req_vec[win*VEC_W +: VEC_W];
            rsp_tag    <= req_tag[win*TAG_W +: TAG_W];
            rsp_id     <= win;
            last_grant <= win;
            chk_valid  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          chk_valid <= 1'b0;
          if (CHK_LAT == 0) begin
            rsp_pass  <= chk_x;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= LAT_LD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            rsp_pass  <= chk_x;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (rsp_pass) begin
              if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
            end else begin
              if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
            end
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_split_check_sched.sv
// tb_split_check_sched: table-driven and scoreboarded bench for the
// split-constraint checker scheduler (CHK_LAT=0 and CHK_LAT=3 instances).
module tb_split_check_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   rv0 = '0, rv3 = '0;
  logic [3:0]   rr0, rr3;
  logic [255:0] req_vec = '0;
  logic [15:0]  req_tag = '0;
  logic         cv0, cv3;
  logic [63:0]  cvec0, cvec3;
  logic         x0 = 1'b0, x3 = 1'b0;
  logic         rsp_ready = 1'b1;
  logic         rspv0, rspv3;
  logic [1:0]   id0, id3;
  logic [3:0]   tag0, tag3;
  logic         pass0, pass3;
  logic [15:0]  pc0, fc0, pc3, fc3;
  logic         busy0, busy3;

  split_check_sched #(.NUM_REQ(4), .VEC_W(64), .TAG_W(4), .CHK_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(rv0), .req_ready(rr0),
    .req_vec(req_vec), .req_tag(req_tag),
    .chk_valid(cv0), .chk_vec(cvec0), .chk_x(x0),
    .rsp_valid(rspv0), .rsp_ready(rsp_ready),
    .rsp_id(id0), .rsp_tag(tag0), .rsp_pass(pass0),
    .pass_cnt(pc0), .fail_cnt(fc0), .busy(busy0)
  );

  split_check_sched #(.NUM_REQ(4), .VEC_W(64), .TAG_W(4), .CHK_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(rv3), .req_ready(rr3),
    .req_vec(req_vec), .req_tag(req_tag),
    .chk_valid(cv3), .chk_vec(cvec3), .chk_x(x3),
    .rsp_valid(rspv3), .rsp_ready(rsp_ready),
    .rsp_id(id3), .rsp_tag(tag3), .rsp_pass(pass3),
    .pass_cnt(pc3), .fail_cnt(fc3), .busy(busy3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] tag;
    logic       pass;
  } rsp_t;

  typedef struct {
    logic [3:0] mask;
    logic       x;
    int         id;
  } vec_t;

  rsp_t        sb[$];
  rsp_t        e_mon;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [15:0] exp_pc = '0, exp_fc = '0;
  logic [15:0] ep3 = '0, ef3 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [3:0] tag_of(input int v, input int r);
    return 4'(v * 3 + r);
  endfunction

  function automatic logic [63:0] vec_of(input int v, input int r);
    return {32'(v), 32'(r + 160)};
  endfunction

  task automatic set_data(input int v);
    for (int r = 0; r < 4; r++) begin
      req_vec[r*64 +: 64] = vec_of(v, r);
      req_tag[r*4 +: 4]   = tag_of(v, r);
    end
  endtask

  // Scoreboard: responses accepted by dut0 are popped in order.
  always @(negedge clk) begin
    if (!rst && rspv0 && rsp_ready) begin
      check("sb_nonempty", 80'(sb.size() != 0), 80'(1));
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        check("rsp0", 80'({id0, tag0, pass0}), 80'(e_mon));
        if (e_mon.pass) exp_pc = sat(exp_pc);
        else exp_fc = sat(exp_fc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check("drain", 80'(sb.size()), 80'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic req0(input logic [3:0] mask, input logic x, input int id,
                      input int v);
    @(posedge clk);
    #1;
    set_data(v);
    rv0 = mask;
    x0  = x;
    sb.push_back('{2'(id), tag_of(v, id), x});
    @(negedge clk);
    check("grant0", 80'(rr0), 80'(4'b1 << id));
    @(posedge clk);
    #1;
    rv0 = '0;
    @(negedge clk);
    check("issue0", 80'({cv0, cvec0}), 80'({1'b1, vec_of(v, id)}));
    drain();
  endtask

  task automatic run3(input logic [3:0] mask, input int id, input logic good,
                      input int v);
    @(posedge clk);
    #1;
    set_data(v);
    rv3 = mask;
    x3  = ~good;
    @(negedge clk);
    check("lat_grant", 80'(rr3), 80'(4'b1 << id));
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      x3 = (k == 4) ? good : ~good;
      if (k == 1) rv3 = '0;
      @(negedge clk);
      if (k == 1)
        check("lat_issue", 80'({cv3, cvec3}), 80'({1'b1, vec_of(v, id)}));
      else if (k < 5)
        check("lat_wait", 80'({rspv3, cv3}), 80'(0));
      else
        check("lat_rsp", 80'({rspv3, id3, tag3, pass3}),
              80'({1'b1, 2'(id), tag_of(v, id), good}));
    end
    if (good) ep3 = sat(ep3);
    else ef3 = sat(ef3);
    @(negedge clk);
    check("lat_cnt", 80'({pc3, fc3}), 80'({ep3, ef3}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic got;
    int   prev;

    tbl[0] = '{4'b1111, 1'b0, 3};
    tbl[1] = '{4'b1111, 1'b1, 0};
    tbl[2] = '{4'b0110, 1'b1, 1};
    tbl[3] = '{4'b0110, 1'b0, 2};
    tbl[4] = '{4'b1001, 1'b1, 3};
    tbl[5] = '{4'b0010, 1'b0, 1};
    tbl[6] = '{4'b1100, 1'b1, 2};
    tbl[7] = '{4'b0001, 1'b0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 80'({rr0, cv0, rspv0, busy0}), 80'(0));
    check("rst_rsp", 80'({id0, tag0, pass0, cvec0}), 80'(0));
    check("rst_cnt", 80'({pc0, fc0, pc3, fc3}), 80'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request, spec vector
    @(posedge clk);
    #1;
    set_data(0);
    req_vec[2*64 +: 64] = 64'hA5;
    req_tag[2*4 +: 4]   = 4'h5;
    rv0 = 4'b0100;
    x0  = 1'b1;
    sb.push_back('{2'd2, 4'h5, 1'b1});
    @(negedge clk);
    check("t1_ready", 80'({rr0, cv0}), 80'({4'b0100, 1'b0}));
    @(posedge clk);
    #1;
    rv0 = '0;
    @(negedge clk);
    check("t1_issue", 80'({cv0, cvec0, rr0}), 80'({1'b1, 64'hA5, 4'b0}));
    @(negedge clk);
    check("t1_rsp_valid", 80'({rspv0, cv0}), 80'({1'b1, 1'b0}));
    drain();
    check("t1_pass_cnt", 80'(pc0), 80'(exp_pc));

    for (int i = 0; i < 8; i++) begin
      req0(tbl[i].mask, tbl[i].x, tbl[i].id, i + 1);
    end
    check("tbl_cnt", 80'({pc0, fc0}), 80'({exp_pc, exp_fc}));

    // Continuous requests from all four after reset
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_pc = '0;
    exp_fc = '0;
    set_data(30);
    x0 = 1'b1;
    for (int g = 0; g < 8; g++) sb.push_back('{2'(g % 4), tag_of(30, g % 4), 1'b1});
    rv0 = 4'hF;
    prev = 0;
    for (int g = 0; g < 8; g++) begin
      got = 1'b0;
      for (int b = 0; b < 8 && !got; b++) begin
        @(negedge clk);
        got = (rr0 != 0);
      end
      check("rr_grant", 80'(rr0), 80'(4'b1 << (g % 4)));
      if (g > 0) check("rr_gap", 80'(cyc - prev), 80'(3));
      prev = cyc;
    end
    @(posedge clk);
    #1;
    rv0 = '0;
    drain();
    check("rr_cnt", 80'({pc0, fc0}), 80'({exp_pc, exp_fc}));

    // Backpressure with a second request waiting
    @(posedge clk);
    #1;
    set_data(20);
    rsp_ready = 1'b0;
    x0  = 1'b0;
    rv0 = 4'b0001;
    sb.push_back('{2'd0, tag_of(20, 0), 1'b0});
    sb.push_back('{2'd1, tag_of(20, 1), 1'b0});
    @(negedge clk);
    check("bp_grant", 80'(rr0), 80'(4'b0001));
    @(posedge clk);
    #1;
    rv0 = 4'b0010;
    got = 1'b0;
    for (int b = 0; b < 6 && !got; b++) begin
      @(negedge clk);
      got = rspv0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", 80'({rspv0, id0, tag0, pass0, rr0, pc0, fc0}),
            80'({1'b1, 2'd0, tag_of(20, 0), 1'b0, 4'b0, exp_pc, exp_fc}));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int b = 0; b < 8 && !got; b++) begin
      @(negedge clk);
      got = (rr0 != 0);
    end
    check("bp_next", 80'(rr0), 80'(4'b0010));
    @(posedge clk);
    #1;
    rv0 = '0;
    drain();
    check("bp_cnt", 80'({pc0, fc0}), 80'({exp_pc, exp_fc}));

    // Fail counter saturation from a preloaded value
    force dut0.fail_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut0.fail_cnt;
    exp_fc = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      req0(4'b0100, 1'b0, 2, 50 + i);
      check("sat_fail", 80'(fc0), 80'(16'hFFFF));
    end
    check("sat_pass", 80'(pc0), 80'(exp_pc));

    // CHK_LAT=3: only the cycle three after chk_valid matters
    run3(4'b0100, 2, 1'b1, 60);
    run3(4'b1000, 3, 1'b0, 61);

    // Reset during WAIT aborts the request
    @(posedge clk);
    #1;
    set_data(40);
    rv3 = 4'b0010;
    @(negedge clk);
    check("rw_grant", 80'(rr3), 80'(4'b0010));
    @(posedge clk);
    #1;
    rv3 = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rw_busy", 80'({busy3, rspv3}), 80'({1'b1, 1'b0}));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rw_abort", 80'({rspv3, busy3, pc3, fc3, pc0, fc0}), 80'(0));
    end
    @(posedge clk);
    #1;
    rv3 = 4'hF;
    @(negedge clk);
    check("rw_first", 80'(rr3), 80'(4'b0001));
    @(posedge clk);
    #1;
    rv3 = '0;
    repeat (8) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/split_check_sched.md
# split_check_sched

Round-robin scheduler that shares one split-constraint checker (a `split_N` predicate with output `x`) among several solver requesters. Each requester offers a packed variable-assignment vector with a tag. The block grants one requester, issues the vector to the checker, and waits the checker's fixed latency. It then samples the verdict and returns it with the requester id and tag over a valid/ready response channel. It sits between the BDD solver's candidate generators and the split-constraint datapath, and keeps saturating pass/fail statistics.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `VEC_W`, 64, width of packed assignment vector
- `TAG_W`, 4, requester-supplied tag width
- `CHK_LAT`, 0, cycles from `chk_valid` to valid `chk_x` (0..15; 0 = combinational checker)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit set
- `req_vec`  in  NUM_REQ*VEC_W  assignment vectors, requester i at bits [i*VEC_W +: VEC_W]
- `req_tag`  in  NUM_REQ*TAG_W  tags, same packing
- `chk_valid`  out  1  vector on `chk_vec` is being issued
- `chk_vec`  out  VEC_W  registered vector driven to checker
- `chk_x`  in  1  checker verdict (1 = constraint satisfied)
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  clog2(NUM_REQ)  granted requester index
- `rsp_tag`  out  TAG_W  tag of that request
- `rsp_pass`  out  1  sampled `chk_x`
- `pass_cnt`  out  16  saturating count of pass responses
- `fail_cnt`  out  16  saturating count of fail responses
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid`, select winner g = first asserted index strictly after `last_grant`, searching cyclically.
  - Assert `req_ready[g]` combinationally in that cycle.
  - Capture `req_vec`/`req_tag` slice g into `chk_vec`/`tag_q`, set `id_q`=g and `last_grant`=g.
  - Go to ISSUE.
  - With no valid requests, stay in IDLE with all `req_ready`=0.
- ISSUE: `chk_valid`=1 for exactly one cycle.
  - If CHK_LAT=0: sample `chk_x` into `pass_q` this cycle, go to RESP.
  - Else: load `lat_cnt`=CHK_LAT-1, go to WAIT.
- WAIT: decrement `lat_cnt`. When `lat_cnt`=0, sample `chk_x` and go to RESP. `chk_x` is ignored in every other cycle.
- RESP:
  - `rsp_valid`=1 with `rsp_id`/`rsp_tag`/`rsp_pass` stable.
  - On `rsp_valid && rsp_ready`: increment `pass_cnt` or `fail_cnt`, holding at 16'hFFFF; go to IDLE.
- `chk_vec` holds its value outside ISSUE. `chk_valid` is the only qualifier.
- `req_ready` is 0 in every state other than IDLE. Requests arriving while busy wait; the block never drops or duplicates a request.
- A requester deasserting `req_valid` before grant is legal; it simply is not selected.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.

## Timing
- Reset values: state=IDLE, `last_grant`=NUM_REQ-1 (so requester 0 wins first), `chk_vec`=0, `chk_valid`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_tag`=0, `rsp_pass`=0, `pass_cnt`=0, `fail_cnt`=0, `busy`=0.
- Latency, grant to `rsp_valid`: CHK_LAT+2 cycles (grant in cycle T, ISSUE at T+1, RESP from T+2+CHK_LAT).
- Peak throughput: one response per CHK_LAT+3 cycles with `rsp_ready` held high. No grant occurs in the cycle of response acceptance; IDLE follows.
- Backpressure: `rsp_ready` low holds RESP indefinitely with outputs stable. Counters are unchanged until the handshake.
- `rst` asserted in any state aborts the in-flight request with no response and no count, and forces the reset values on the next edge.

## Test plan
- Reset then single request: `req_valid`=4'b0100, tag 0x5, vec 0xA5, `chk_x`=1, CHK_LAT=0 -> `req_ready`=4'b0100 for one cycle; `chk_valid` one cycle later with `chk_vec`=0xA5; `rsp_valid` at grant+2 with id=2, tag=0x5, pass=1; `pass_cnt`=1.
- All four requesting continuously, `rsp_ready`=1 -> grant order 0,1,2,3,0,…; responses every 3 cycles.
- CHK_LAT=3, `chk_x` driven 0 except 1 exactly 3 cycles after `chk_valid` -> `rsp_pass`=1, `rsp_valid` at grant+5; a glitch on `chk_x` in other cycles has no effect.
- `rsp_ready`=0 for 10 cycles in RESP -> outputs stable; `req_ready` all 0; counters frozen; one count after release.
- Preload `fail_cnt` to 16'hFFFE, then 3 failing responses -> `fail_cnt` sticks at 16'hFFFF.
- `rst` pulsed during WAIT -> no `rsp_valid`; counters 0; the next request is granted to requester 0 first.
